// File: rtl/fpga1.sv
// fpga1 -- self-checking 4-input LUT cell.
// Holds the 16-bit truth table in a primary and a shadow copy. Each copy
// carries a stored even-parity bit. The output e comes from the primary copy.
// Any disagreement between the two copies sets a sticky err flag, and so does
// any parity violation in either copy.
module fpga1 #(
    parameter logic [15:0] INIT = 16'h6996
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic       cfg_data,
    input  logic       inj_fault,
    output logic       e,
    output logic       err
);

    // Even parity over a 16-bit truth table copy.
    function automatic logic f_parity16(input logic [15:0] v);
        return ^v;
    endfunction

    logic [15:0] r_prim;
    logic [15:0] r_shad;
    logic        r_par_p;
    logic        r_par_s;
    logic        r_e;
    logic        r_err;

    logic [3:0]  w_idx;
    logic [15:0] w_prim_next;
    logic [15:0] w_shad_next;
    logic        w_lut_p;
    logic        w_lut_s;
    logic        w_mismatch;
    logic        w_perr_p;
    logic        w_perr_s;
    logic        w_any_err;

    assign w_idx = {a, b, c, d};

    // Next table contents: a config write patches one bit in both copies.
    always_comb begin
        w_prim_next = r_prim;
        w_shad_next = r_shad;
        if (cfg_we) begin
            w_prim_next[cfg_addr] = cfg_data;
            w_shad_next[cfg_addr] = cfg_data;
        end else begin
            w_prim_next = r_prim;
            w_shad_next = r_shad;
        end
    end

    // Lookup and integrity checks. These use the current (pre-write) tables.
    always_comb begin
        w_lut_p    = r_prim[w_idx] ^ inj_fault;
        w_lut_s    = r_shad[w_idx];
        w_mismatch = (w_lut_p != w_lut_s);
        w_perr_p   = (f_parity16(r_prim) != r_par_p);
        w_perr_s   = (f_parity16(r_shad) != r_par_s);
        w_any_err  = w_mismatch | w_perr_p | w_perr_s;
    end

    // Truth-table copies and their parity bits. Both parity bits are
    // recomputed on the same edge as the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prim  <= INIT;
            r_shad  <= INIT;
            r_par_p <= f_parity16(INIT);
            r_par_s <= f_parity16(INIT);
        end else begin
            r_prim  <= w_prim_next;
            r_shad  <= w_shad_next;
            r_par_p <= f_parity16(w_prim_next);
            r_par_s <= f_parity16(w_shad_next);
        end
    end

    // Registered LUT output and sticky error flag. A config write never
    // clears err; only reset does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e   <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_e   <= w_lut_p;
            r_err <= r_err | w_any_err;
        end
    end

    assign e   = r_e;
    assign err = r_err;

endmodule

// File: tb/tb_fpga1.sv
// tb_fpga1 -- scoreboard bench for the fpga1 LUT cell.
// The driver computes expected (e, err) from a plain 16-bit table model and
// queues them. A monitor compares each queued entry after the next rising edge.
module tb_fpga1;

    localparam logic [15:0] INIT = 16'h6996;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = 4'd0;
    logic       cfg_data = 1'b0;
    logic       inj_fault = 1'b0;
    logic       e;
    logic       err;

    fpga1 #(.INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .inj_fault(inj_fault),
        .e(e), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic e;
        logic err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    string       phase    = "init";
    logic [15:0] m_tbl    = INIT;
    logic        m_err    = 1'b0;

    task automatic check(input string name, input logic act_e, input logic act_err,
                         input logic exp_e, input logic exp_err);
        n_checks++;
        if (act_e === exp_e && act_err === exp_err) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got e=%b err=%b, expected e=%b err=%b",
                     name, $time, act_e, act_err, exp_e, exp_err);
        end
    endtask

    // One clock of stimulus. The model output is the pre-write table bit,
    // inverted by the fault injection. Any injected fault makes the copies
    // disagree, so the sticky error flag sets.
    task automatic step(input logic [3:0] idx, input logic we, input logic [3:0] addr,
                        input logic dat, input logic inj);
        exp_t x;
        @(negedge clk);
        {a, b, c, d} = idx;
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_data  = dat;
        inj_fault = inj;
        x.e   = m_tbl[idx] ^ inj;
        m_err = m_err | inj;
        x.err = m_err;
        sb_q.push_back(x);
        if (we) m_tbl[addr] = dat;
    endtask

    // Asserts reset between clock edges and checks that the outputs clear at once.
    task automatic async_reset();
        @(negedge clk);
        cfg_we = 1'b0;
        inj_fault = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", e, err, 1'b0, 1'b0);
        m_tbl = INIT;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: after each rising edge, pop one expectation if one is pending.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check(phase, e, err, x.e, x.err);
        end
    end

    initial begin
        logic [3:0] seq [7];
        seq = '{4'b0000, 4'b1100, 4'b1101, 4'b0101, 4'b0001, 4'b1001, 4'b1111};

        #3 check("reset_state", e, err, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "first_after_reset";
        step(4'b0000, 1'b0, 4'd0, 1'b0, 1'b0);

        phase = "default_xor";
        foreach (seq[i]) step(seq[i], 1'b0, 4'd0, 1'b0, 1'b0);

        phase = "and_config";
        for (int i = 0; i < 16; i++) step(4'b0000, 1'b1, 4'(i), (i == 15), 1'b0);
        step(4'b1111, 1'b0, 4'd0, 1'b0, 1'b0);
        step(4'b1101, 1'b0, 4'd0, 1'b0, 1'b0);

        async_reset();
        phase = "after_mid_reset";
        step(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);

        phase = "fault_inject";
        step(4'b0001, 1'b0, 4'd0, 1'b0, 1'b1);
        phase = "fault_sticky";
        step(4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 4'd3, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'd0, 1'b0, 1'b0);

        async_reset();
        phase = "write_same_edge";
        step(4'b1111, 1'b1, 4'd15, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'd0, 1'b0, 1'b0);

        phase = "random_clean";
        for (int i = 0; i < 150; i++)
            step(4'($urandom_range(15)), ($urandom_range(3) == 0),
                 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b0);

        async_reset();
        phase = "random_fault";
        for (int i = 0; i < 150; i++)
            step(4'($urandom_range(15)), ($urandom_range(3) == 0),
                 4'($urandom_range(15)), 1'($urandom_range(1)),
                 ($urandom_range(19) == 0));

        @(negedge clk);
        cfg_we = 1'b0;
        inj_fault = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
